// File: rtl/leaf_stream_bridge.sv
// rtl/leaf_stream_bridge.sv - BFT leaf bridge: routed ingress FIFOs per port, round-robin egress with replay
module leaf_stream_bridge #(
    parameter int PACKET_BITS   = 49,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 5,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int NUM_IN_PORTS  = 2,
    parameter int NUM_OUT_PORTS = 2,
    parameter int FIFO_DEPTH    = 16,
    parameter int SELF_LEAF     = 6
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic [PACKET_BITS-1:0]                                din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0]                                dout_leaf_interface2bft,
    input  logic                                                  resend,
    input  logic [NUM_OUT_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)-1:0] dest_cfg,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]                  dout_leaf_interface2user,
    output logic [NUM_IN_PORTS-1:0]                               vld_interface2user,
    input  logic [NUM_IN_PORTS-1:0]                               ack_user2interface,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]                 din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                              vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                              ack_interface2user,
    output logic [15:0]                                           drop_count
);
    localparam int DEST_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int FIFO_AW   = $clog2(FIFO_DEPTH);
    localparam int PTR_W     = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam int CW        = PTR_W + 1;
    localparam logic [NUM_LEAF_BITS-1:0] SELF_ID = NUM_LEAF_BITS'(SELF_LEAF);

    logic                     in_valid;
    logic [NUM_LEAF_BITS-1:0] in_leaf;
    logic [NUM_PORT_BITS-1:0] in_port;
    logic [PAYLOAD_BITS-1:0]  in_payload;
    logic                     unused_in_seq;
    logic                     routed;
    logic                     drop;

    assign in_valid      = din_leaf_bft2interface[PACKET_BITS-1];
    assign in_leaf       = din_leaf_bft2interface[PACKET_BITS-2 -: NUM_LEAF_BITS];
    assign in_port       = din_leaf_bft2interface[PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS];
    assign in_payload    = din_leaf_bft2interface[PAYLOAD_BITS-1:0];
    assign unused_in_seq = ^din_leaf_bft2interface[PAYLOAD_BITS +: NUM_ADDR_BITS];
    assign routed        = in_valid && (in_leaf == SELF_ID) && (32'(in_port) < NUM_IN_PORTS);

    logic [NUM_IN_PORTS-1:0] push;
    logic [NUM_IN_PORTS-1:0] pop;
    logic [NUM_IN_PORTS-1:0] full;

    generate
        for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_fifo
            logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
            logic [FIFO_AW:0]        wr_ptr;
            logic [FIFO_AW:0]        rd_ptr;
            logic                    empty;

            assign empty   = (wr_ptr == rd_ptr);
            assign full[i] = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                             (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
            assign vld_interface2user[i] = ~empty;
            assign pop[i]  = ~empty & ack_user2interface[i];
            // A full FIFO still takes the push when its head leaves in the same cycle.
            assign push[i] = routed && (32'(in_port) == i) && (~full[i] || pop[i]);
            assign dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS] =
                empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    if (push[i]) wr_ptr <= wr_ptr + 1'b1;
                    if (pop[i])  rd_ptr <= rd_ptr + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (push[i]) mem[wr_ptr[FIFO_AW-1:0]] <= in_payload;
            end
        end
    endgenerate

    assign drop = in_valid && ~(|push);

    // Egress only starts arbitrating after the first edge following reset release.
    logic                     run;
    logic [PTR_W-1:0]         rr_ptr;
    logic [CW-1:0]            cand;
    logic                     grant_any;
    logic [PTR_W-1:0]         grant_idx;
    logic [PTR_W-1:0]         next_ptr;
    logic [NUM_ADDR_BITS-1:0] seq [NUM_OUT_PORTS];
    logic [PACKET_BITS-1:0]   replay;
    logic [PACKET_BITS-1:0]   new_pkt;
    logic [DEST_BITS-1:0]     grant_dest;
    logic [PAYLOAD_BITS-1:0]  grant_payload;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_OUT_PORTS; k++) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= CW'(NUM_OUT_PORTS)) cand = cand - CW'(NUM_OUT_PORTS);
            if (!grant_any && vld_user2interface[cand[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
        if (resend || !run) grant_any = 1'b0;
    end

    always_comb begin
        ack_interface2user = '0;
        if (grant_any) ack_interface2user[grant_idx] = 1'b1;
    end

    assign next_ptr      = (32'(grant_idx) == NUM_OUT_PORTS - 1) ? '0 : grant_idx + 1'b1;
    assign grant_dest    = dest_cfg[grant_idx*DEST_BITS +: DEST_BITS];
    assign grant_payload = din_leaf_user2interface[grant_idx*PAYLOAD_BITS +: PAYLOAD_BITS];
    assign new_pkt       = {1'b1, grant_dest, seq[grant_idx], grant_payload};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run                     <= 1'b0;
            rr_ptr                  <= '0;
            dout_leaf_interface2bft <= '0;
            replay                  <= '0;
            drop_count              <= '0;
            for (int c = 0; c < NUM_OUT_PORTS; c++) seq[c] <= '0;
        end else begin
            run <= 1'b1;
            if (resend) begin
                dout_leaf_interface2bft <= replay;
            end else if (grant_any) begin
                dout_leaf_interface2bft <= new_pkt;
                replay                  <= new_pkt;
                seq[grant_idx]          <= seq[grant_idx] + 1'b1;
                rr_ptr                  <= next_ptr;
            end else begin
                dout_leaf_interface2bft <= '0;
            end
            if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_leaf_stream_bridge.sv
// tb/tb_leaf_stream_bridge.sv - scoreboard bench for leaf_stream_bridge with queue-based reference model
module tb_leaf_stream_bridge;
    localparam int PB = 49, PLB = 32, NLB = 5, NPB = 4, NAB = 7;
    localparam int NIN = 2, NOUT = 2, FD = 16, SELF = 6;
    localparam int DW = NLB + NPB;

    logic                clk = 1'b0;
    logic                reset;
    logic [PB-1:0]       din_bft;
    logic [PB-1:0]       dout_bft;
    logic                resend;
    logic [NOUT*DW-1:0]  dest_cfg;
    logic [NIN*PLB-1:0]  dout_user;
    logic [NIN-1:0]      vld_i2u;
    logic [NIN-1:0]      ack_u2i;
    logic [NOUT*PLB-1:0] din_user;
    logic [NOUT-1:0]     vld_u2i;
    logic [NOUT-1:0]     ack_i2u;
    logic [15:0]         drop_count;

    always #5 clk = ~clk;

    leaf_stream_bridge dut (
        .clk                      (clk),
        .reset                    (reset),
        .din_leaf_bft2interface   (din_bft),
        .dout_leaf_interface2bft  (dout_bft),
        .resend                   (resend),
        .dest_cfg                 (dest_cfg),
        .dout_leaf_interface2user (dout_user),
        .vld_interface2user       (vld_i2u),
        .ack_user2interface       (ack_u2i),
        .din_leaf_user2interface  (din_user),
        .vld_user2interface       (vld_u2i),
        .ack_interface2user       (ack_i2u),
        .drop_count               (drop_count)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain payload queues per ingress port, per-channel sequence numbers.
    logic [PLB-1:0] mq [NIN][$];
    logic [NAB-1:0] mseq [NOUT];
    logic [PB-1:0]  mlast;
    int             mstart;
    int             mdrop;

    typedef struct packed {
        logic [PB-1:0]      bft;
        logic [NIN-1:0]     vld;
        logic [NIN*PLB-1:0] heads;
        logic [15:0]        drop;
    } post_t;

    post_t          post_q [$];
    logic [NOUT-1:0] ack_q [$];

    task automatic model_reset();
        for (int i = 0; i < NIN; i++) mq[i].delete();
        for (int c = 0; c < NOUT; c++) mseq[c] = '0;
        mlast  = '0;
        mstart = 0;
        mdrop  = 0;
    endtask

    task automatic step(input logic [PB-1:0] d, input logic [NIN-1:0] a, input logic [NOUT-1:0] v,
                        input logic [NOUT*PLB-1:0] du, input logic rs);
        logic [NIN-1:0]  popm;
        logic [NOUT-1:0] acke;
        post_t           e;
        int              lf, pt, g, c, push_port;
        @(negedge clk);
        din_bft = d; ack_u2i = a; vld_u2i = v; din_user = du; resend = rs;
        for (int i = 0; i < NIN; i++) popm[i] = a[i] && (mq[i].size() > 0);
        push_port = -1;
        if (d[PB-1]) begin
            lf = int'(d[PB-2 -: NLB]);
            pt = int'(d[PB-2-NLB -: NPB]);
            if (lf == SELF && pt < NIN && (mq[pt].size() < FD || popm[pt])) push_port = pt;
            else if (mdrop < 65535) mdrop++;
        end
        for (int i = 0; i < NIN; i++) if (popm[i]) void'(mq[i].pop_front());
        if (push_port >= 0) mq[push_port].push_back(d[PLB-1:0]);
        acke = '0;
        if (rs) begin
            e.bft = mlast;
        end else begin
            g = -1;
            for (int k = 0; k < NOUT; k++) begin
                c = (mstart + k) % NOUT;
                if (g < 0 && v[c]) g = c;
            end
            if (g >= 0) begin
                acke[g] = 1'b1;
                e.bft   = {1'b1, dest_cfg[g*DW +: DW], mseq[g], du[g*PLB +: PLB]};
                mlast   = e.bft;
                mseq[g] = mseq[g] + 1'b1;
                mstart  = (g + 1) % NOUT;
            end else begin
                e.bft = '0;
            end
        end
        for (int i = 0; i < NIN; i++) begin
            e.vld[i] = mq[i].size() > 0;
            e.heads[i*PLB +: PLB] = e.vld[i] ? mq[i][0] : '0;
        end
        e.drop = 16'(mdrop);
        ack_q.push_back(acke);
        post_q.push_back(e);
    endtask

    initial begin
        post_t           e;
        logic [NOUT-1:0] ea;
        forever begin
            @(negedge clk);
            #2;
            if (ack_q.size() > 0) begin
                ea = ack_q.pop_front();
                chk("egress_ack", 64'(ack_i2u), 64'(ea));
            end
            @(posedge clk);
            #1;
            if (post_q.size() > 0) begin
                e = post_q.pop_front();
                chk("bft_packet", 64'(dout_bft), 64'(e.bft));
                chk("ingress_vld", 64'(vld_i2u), 64'(e.vld));
                chk("drop_count", 64'(drop_count), 64'(e.drop));
                for (int i = 0; i < NIN; i++)
                    if (e.vld[i]) chk($sformatf("ingress_head%0d", i),
                                      64'(dout_user[i*PLB +: PLB]), 64'(e.heads[i*PLB +: PLB]));
            end
        end
    end

    task automatic release_reset();
        din_bft = '0; ack_u2i = '0; resend = 1'b0; din_user = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ack_before_first_edge", 64'(ack_i2u), 64'd0);
        @(posedge clk);
        vld_u2i = '0;
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            logic [PB-1:0]  d;
            logic [NLB-1:0] lf;
            logic [NPB-1:0] pt;
            lf = ($urandom_range(0, 4) == 0) ? NLB'($urandom) : NLB'(SELF);
            pt = NPB'($urandom_range(0, 2));
            d  = {($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, lf, pt, NAB'($urandom), PLB'($urandom)};
            step(d, NIN'($urandom), NOUT'($urandom), {$urandom, $urandom}, $urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        reset = 1'b0;
        din_bft = '0; ack_u2i = '0; resend = 1'b0; din_user = '0; vld_u2i = 2'b11;
        dest_cfg = {5'd4, 4'd0, 5'd3, 4'd2};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bft", 64'(dout_bft), 64'd0);
        chk("reset_vld", 64'(vld_i2u), 64'd0);
        chk("reset_drop", 64'(drop_count), 64'd0);
        chk("reset_ack", 64'(ack_i2u), 64'd0);
        release_reset();

        step('0, '0, 2'b11, {32'hB0B0_0001, 32'hA0A0_0001}, 1'b1);
        for (int i = 0; i < 4; i++) step('0, '0, 2'b11, {32'hB000_0000 + i, 32'hA000_0000 + i}, 1'b0);
        step('0, '0, 2'b01, {32'h0, 32'h0000_1234}, 1'b0);
        step('0, '0, 2'b01, {32'h0, 32'h5555_5555}, 1'b1);
        step('0, '0, 2'b00, '0, 1'b0);
        for (int i = 0; i < 130; i++) step('0, '0, 2'b01, {32'h0, PLB'(i)}, 1'b0);

        step({1'b1, 5'd6, 4'd1, 7'd0, 32'hDEADBEEF}, 2'b00, '0, '0, 1'b0);
        step('0, 2'b00, '0, '0, 1'b0);
        step('0, 2'b10, '0, '0, 1'b0);
        step({1'b1, 5'd5, 4'd0, 7'd0, 32'h1}, 2'b00, '0, '0, 1'b0);
        for (int i = 0; i < 17; i++) step({1'b1, 5'd6, 4'd0, 7'd0, PLB'(i)}, 2'b00, '0, '0, 1'b0);
        step({1'b1, 5'd6, 4'd0, 7'd0, 32'h77}, 2'b01, '0, '0, 1'b0);
        for (int i = 0; i < 17; i++) step('0, 2'b01, '0, '0, 1'b0);

        rand_cycles(3000);

        for (int i = 0; i < 3; i++) step({1'b1, 5'd6, 4'd0, 7'd0, PLB'(i)}, '0, '0, '0, 1'b0);
        for (int i = 0; i < 2; i++) step({1'b1, 5'd6, 4'd1, 7'd0, PLB'(i)}, '0, 2'b01, {32'h0, 32'h99}, 1'b0);
        @(posedge clk);
        #3;
        vld_u2i = 2'b11;
        reset = 1'b0;
        #1;
        chk("async_bft", 64'(dout_bft), 64'd0);
        chk("async_vld", 64'(vld_i2u), 64'd0);
        chk("async_user_data", 64'(dout_user), 64'd0);
        chk("async_drop", 64'(drop_count), 64'd0);
        chk("async_ack", 64'(ack_i2u), 64'd0);
        model_reset();
        dest_cfg = NOUT*DW'({$urandom, $urandom});
        release_reset();
        step('0, '0, 2'b11, {32'h2222_2222, 32'h1111_1111}, 1'b0);
        rand_cycles(500);

        @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
        release_reset();
        for (int i = 0; i < 65540; i++) step({1'b1, 5'd5, 4'd0, 7'd0, 32'h0}, '0, '0, '0, 1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
